// File: rtl/ic_hc_dctab_arbiter_pkg.sv
// Shared Huffman-coding constants and the DC table ROM entry layout.
package ic_hc_pkg;

    localparam int DC_CAT_W   = 4;
    localparam int HC_ENTRY_W = 21;
    localparam int HC_LEN_W   = 5;
    localparam int HC_CODE_W  = 16;
    localparam int LEN_MSB    = 20;
    localparam int LEN_LSB    = 16;
    localparam int CODE_MSB   = 15;
    localparam int DC_NUM_CAT = 12;

    // One ROM word: code length on top, right-aligned code below.
    typedef struct packed {
        logic [HC_LEN_W-1:0]  len;
        logic [HC_CODE_W-1:0] code;
    } hc_entry_t;

    function automatic hc_entry_t hc_unpack(input logic [HC_ENTRY_W-1:0] w);
        hc_entry_t e;
        e.len  = w[LEN_MSB:LEN_LSB];
        e.code = w[CODE_MSB:0];
        return e;
    endfunction

endpackage

// File: rtl/ic_hc_dctab_arbiter_if.sv
// Two-lane DC table lookup bus plus the shared ROM port.
interface ic_hc_dctab_arbiter_if
    import ic_hc_pkg::*;
#(
    parameter int ADDR_W  = DC_CAT_W,
    parameter int ENTRY_W = HC_ENTRY_W
);
    logic                 req0_valid;
    logic [ADDR_W-1:0]    req0_cat;
    logic                 req0_ready;
    logic                 rsp0_valid;
    logic                 rsp0_ready;
    logic [HC_CODE_W-1:0] rsp0_code;
    logic [HC_LEN_W-1:0]  rsp0_len;
    logic                 rsp0_err;

    logic                 req1_valid;
    logic [ADDR_W-1:0]    req1_cat;
    logic                 req1_ready;
    logic                 rsp1_valid;
    logic                 rsp1_ready;
    logic [HC_CODE_W-1:0] rsp1_code;
    logic [HC_LEN_W-1:0]  rsp1_len;
    logic                 rsp1_err;

    logic [ADDR_W-1:0]    rom_address;
    logic [ENTRY_W-1:0]   rom_q;

    // Lanes, consumers and the ROM together form the master side.
    modport master (
        output req0_valid, req0_cat, rsp0_ready,
        output req1_valid, req1_cat, rsp1_ready,
        output rom_q,
        input  req0_ready, rsp0_valid, rsp0_code, rsp0_len, rsp0_err,
        input  req1_ready, rsp1_valid, rsp1_code, rsp1_len, rsp1_err,
        input  rom_address
    );

    modport slave (
        input  req0_valid, req0_cat, rsp0_ready,
        input  req1_valid, req1_cat, rsp1_ready,
        input  rom_q,
        output req0_ready, rsp0_valid, rsp0_code, rsp0_len, rsp0_err,
        output req1_ready, rsp1_valid, rsp1_code, rsp1_len, rsp1_err,
        output rom_address
    );

endinterface

// File: rtl/ic_hc_dctab_arbiter_rr_arb2.sv
// Two-request round-robin arbiter, one-hot grant, last-grant register.
module ic_hc_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    // last=1 after reset so lane 0 wins the first tie.
    logic last;

    // Grant: single requester wins outright, a tie goes to the lane not granted last.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Remember the most recent winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (|gnt)
            last <= gnt[1];
    end

endmodule

// File: rtl/ic_hc_dctab_arbiter.sv
// Shares one DC Huffman table ROM between two encoder lanes.
module ic_hc_dctab_arbiter
    import ic_hc_pkg::*;
#(
    parameter int NUM_ENTRIES = DC_NUM_CAT,
    parameter int ADDR_W      = DC_CAT_W,
    parameter int ENTRY_W     = HC_ENTRY_W
) (
    input logic                  clock,
    input logic                  aclr,
    ic_hc_dctab_arbiter_if.slave bus
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]             req_valid;
    logic [NUM_LANES-1:0]             rsp_ready;
    logic [NUM_LANES-1:0][ADDR_W-1:0] req_cat;
    logic [NUM_LANES-1:0]             elig;
    logic [NUM_LANES-1:0]             gnt;
    logic [ADDR_W-1:0]                gnt_cat;

    logic                             s1_valid;
    logic                             s1_id;
    logic                             s1_err;

    logic [ENTRY_W-1:0]               rom_word;
    hc_entry_t                        rom_entry;

    logic [NUM_LANES-1:0]             rsp_valid_q;
    logic [NUM_LANES-1:0]             rsp_err_q;
    hc_entry_t [NUM_LANES-1:0]        rsp_entry_q;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_cat   = {bus.req1_cat, bus.req0_cat};

    // A lane may issue if it has nothing in stage 1 and its response slot is free or draining now.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_LANES; i++)
            elig[i] = req_valid[i] && !(s1_valid && (s1_id == 1'(i))) &&
                      (!rsp_valid_q[i] || rsp_ready[i]);
    end

    ic_hc_rr_arb2 u_arb (
        .clk (clock),
        .rst (aclr),
        .req (elig),
        .gnt (gnt)
    );

    assign gnt_cat         = gnt[1] ? req_cat[1] : req_cat[0];
    assign bus.rom_address = (|gnt) ? gnt_cat : '0;
    assign bus.req0_ready  = gnt[0];
    assign bus.req1_ready  = gnt[1];

    // Stage 1: track which lane owns the ROM read in flight and whether its category was bad.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= |gnt;
            s1_id    <= gnt[1];
            s1_err   <= ({1'b0, gnt_cat} >= (ADDR_W+1)'(NUM_ENTRIES));
        end
    end

    assign rom_word  = bus.rom_q;
    assign rom_entry = hc_unpack(rom_word);

    // Response slots: a landing lookup wins over a drain, so refill-while-draining keeps valid high.
    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_entry_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (s1_valid && (s1_id == 1'(i))) begin
                    rsp_valid_q[i] <= 1'b1;
                    rsp_err_q[i]   <= s1_err;
                    rsp_entry_q[i] <= s1_err ? '0 : rom_entry;
                end else if (rsp_ready[i]) begin
                    rsp_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp0_code  = rsp_entry_q[0].code;
    assign bus.rsp0_len   = rsp_entry_q[0].len;
    assign bus.rsp0_err   = rsp_err_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp1_code  = rsp_entry_q[1].code;
    assign bus.rsp1_len   = rsp_entry_q[1].len;
    assign bus.rsp1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_ic_hc_dctab_arbiter.sv
// Directed bench for the shared DC table arbiter with a ROM model and per-lane scoreboards.
module tb_ic_hc_dctab_arbiter;
    import ic_hc_pkg::*;

    logic clock = 1'b0;
    logic aclr;
    always #5 clock = ~clock;

    ic_hc_dctab_arbiter_if bus ();

    ic_hc_dctab_arbiter dut (
        .clock (clock),
        .aclr  (aclr),
        .bus   (bus.slave)
    );

    // ROM model: registered address, data valid the following cycle.
    logic [3:0] rom_addr_q;
    always_ff @(posedge clock) rom_addr_q <= bus.rom_address;

    function automatic logic [20:0] rom_word(input logic [3:0] a);
        if (a < 4'd12) return {5'(a + 4'd2), 16'(16'(a) * 16'h0123)};
        return 21'h1FFFFF;
    endfunction

    assign bus.rom_q = rom_word(rom_addr_q);

    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int total = 0;
    int bad   = 0;

    logic       m_s1v, m_s1id, m_last;
    logic [1:0] m_rspv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expect_for(input logic [3:0] c);
        exp_t e;
        if (c >= 4'd12) begin
            e.code = 16'h0; e.len = 5'h0; e.err = 1'b1;
        end else begin
            e.code = 16'(16'(c) * 16'h0123); e.len = 5'(c + 4'd2); e.err = 1'b0;
        end
        return e;
    endfunction

    task automatic reset_model();
        m_s1v = 1'b0; m_s1id = 1'b0; m_last = 1'b1; m_rspv = 2'b00;
        q0.delete(); q1.delete();
    endtask

    // Independent model of grant/valid behaviour plus scoreboard push/pop, run once per cycle.
    task automatic monitor();
        logic [1:0] el, g, nx;
        logic [3:0] ea;
        exp_t e;
        el[0] = bus.req0_valid && !(m_s1v && !m_s1id) && (!m_rspv[0] || bus.rsp0_ready);
        el[1] = bus.req1_valid && !(m_s1v &&  m_s1id) && (!m_rspv[1] || bus.rsp1_ready);
        g = (el == 2'b11) ? (m_last ? 2'b01 : 2'b10) : el;
        ea = g[0] ? bus.req0_cat : (g[1] ? bus.req1_cat : 4'd0);
        chk("grant", 32'({bus.req1_ready, bus.req0_ready}), 32'(g));
        chk("rom_address", 32'(bus.rom_address), 32'(ea));
        chk("rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'(m_rspv));
        if (g[0]) q0.push_back(expect_for(bus.req0_cat));
        if (g[1]) q1.push_back(expect_for(bus.req1_cat));
        if (bus.rsp0_valid && bus.rsp0_ready) begin
            chk("rsp0_pending", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("rsp0_data", 32'({bus.rsp0_code, bus.rsp0_len, bus.rsp0_err}), 32'(e));
            end
        end
        if (bus.rsp1_valid && bus.rsp1_ready) begin
            chk("rsp1_pending", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("rsp1_data", 32'({bus.rsp1_code, bus.rsp1_len, bus.rsp1_err}), 32'(e));
            end
        end
        nx[0] = (m_s1v && !m_s1id) ? 1'b1 : (bus.rsp0_ready ? 1'b0 : m_rspv[0]);
        nx[1] = (m_s1v &&  m_s1id) ? 1'b1 : (bus.rsp1_ready ? 1'b0 : m_rspv[1]);
        m_rspv = nx;
        m_s1v  = |g;
        m_s1id = g[1];
        if (|g) m_last = g[1];
    endtask

    task automatic cyc();
        @(negedge clock);
        if (!aclr) monitor();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [21:0] held;
        logic        hv;
        logic [3:0]  cats [4];
        cats[0] = 4'd11; cats[1] = 4'd12; cats[2] = 4'd15; cats[3] = 4'd1;

        // Reset with both lanes requesting: nothing may be granted.
        aclr = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_cat = 4'd3; bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_cat = 4'd5; bus.rsp1_ready = 1'b1;
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
        chk("rst_rsp_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        chk("rst_rsp0_fields", 32'({bus.rsp0_code, bus.rsp0_len, bus.rsp0_err}), 32'd0);
        chk("rst_rsp1_fields", 32'({bus.rsp1_code, bus.rsp1_len, bus.rsp1_err}), 32'd0);
        chk("rst_rom_address", 32'(bus.rom_address), 32'd0);

        // Contention: lane 0 wins the first tie, then grants alternate.
        aclr = 1'b0;
        #1;
        chk("first_tie_lane0", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
        repeat (12) cyc();

        // Backpressure on lane 1 while lane 0 keeps being served.
        bus.req0_cat = 4'd7; bus.req1_cat = 4'd9; bus.rsp1_ready = 1'b0;
        hv = 1'b0; held = '0;
        repeat (8) begin
            cyc();
            if (bus.rsp1_valid) begin
                if (hv) chk("rsp1_hold", 32'({bus.rsp1_code, bus.rsp1_len, bus.rsp1_err}), 32'(held));
                held = {bus.rsp1_code, bus.rsp1_len, bus.rsp1_err};
                hv = 1'b1;
            end
        end
        bus.rsp1_ready = 1'b1;
        repeat (2) cyc();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (4) cyc();

        // Single lane, cat 0: grant and address in T, response in T+2.
        bus.req0_valid = 1'b1; bus.req0_cat = 4'd0; bus.rsp0_ready = 1'b0;
        #1;
        chk("single_ready", 32'(bus.req0_ready), 32'd1);
        chk("single_addr", 32'(bus.rom_address), 32'd0);
        cyc();
        bus.req0_valid = 1'b0;
        cyc();
        chk("single_valid_t2", 32'(bus.rsp0_valid), 32'd1);
        chk("single_fields", 32'({bus.rsp0_code, bus.rsp0_len, bus.rsp0_err}), 32'({16'h0, 5'd2, 1'b0}));
        bus.rsp0_ready = 1'b1;
        cyc();

        // Out-of-range category on lane 1: error flagged, ROM data ignored.
        bus.req1_valid = 1'b1; bus.req1_cat = 4'd13; bus.rsp1_ready = 1'b0;
        #1;
        chk("oor_ready", 32'(bus.req1_ready), 32'd1);
        cyc();
        bus.req1_valid = 1'b0;
        cyc();
        chk("oor_valid_t2", 32'(bus.rsp1_valid), 32'd1);
        chk("oor_fields", 32'({bus.rsp1_code, bus.rsp1_len, bus.rsp1_err}), 32'({16'h0, 5'd0, 1'b1}));
        bus.rsp1_ready = 1'b1;
        cyc();
        bus.req1_valid = 1'b1; bus.req1_cat = 4'd11;
        cyc();
        bus.req1_valid = 1'b0;
        repeat (3) cyc();

        // Boundary categories on lane 0, consumer always ready: results land while draining.
        bus.req0_valid = 1'b1;
        foreach (cats[k]) begin
            bus.req0_cat = cats[k];
            repeat (2) cyc();
        end
        bus.req0_valid = 1'b0;
        repeat (4) cyc();
        chk("q_empty_mid", 32'(q0.size() + q1.size()), 32'd0);

        // Reset mid-flight: lane 1 holds a response, lane 0 has a lookup in stage 1.
        bus.rsp1_ready = 1'b0; bus.req1_valid = 1'b1; bus.req1_cat = 4'd4;
        cyc();
        bus.req1_valid = 1'b0;
        repeat (2) cyc();
        bus.req0_valid = 1'b1; bus.req0_cat = 4'd6; bus.rsp0_ready = 1'b0;
        #1;
        chk("mid_grant", 32'(bus.req0_ready), 32'd1);
        cyc();
        bus.req0_valid = 1'b0;
        aclr = 1'b1;
        #1;
        chk("mid_rst_valid", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        chk("mid_rst_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
        bus.req0_valid = 1'b1; bus.req0_cat = 4'd2; bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_cat = 4'd8; bus.rsp1_ready = 1'b1;
        aclr = 1'b0;
        #1;
        chk("post_rst_tie_lane0", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
        repeat (8) cyc();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (4) cyc();
        chk("q_empty_end", 32'(q0.size() + q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
